// File: rtl/regfile_mp.sv
// Multi-port register file with W0/W1 write-back bypass, per-register
// in-flight producer counters, issue handshake and a registered display tap.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int CNT_W    = 2,
    parameter int ARG_W    = 6,
    parameter int TAP_LO   = 12,
    parameter int TAP_HI   = 13,
    parameter int TAP_HI_W = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [ARG_W-1:0]           arguments,
    input  logic [NRD*ADDR_W-1:0]      rd_addr,
    output logic [NRD*DATA_W-1:0]      rd_data,
    output logic [NRD-1:0]             rd_busy,
    input  logic                       we0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       we1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_addr,
    output logic                       iss_ready,
    output logic                       err_underflow,
    output logic [DATA_W+TAP_HI_W-1:0] test_result
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int SW    = CNT_W + 2;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [CNT_W-1:0]  cnt     [DEPTH];
    logic [CNT_W-1:0]  cnt_nxt [DEPTH];
    logic [1:0]        dec     [DEPTH];
    logic [SW-1:0]     sum     [DEPTH];
    logic              uf_any;
    logic              iss_fire;

    assign iss_ready = (iss_addr == '0) || (cnt[iss_addr] != CMAX);
    assign iss_fire  = iss_valid && iss_ready && (iss_addr != '0);

    // dec counts retiring producers; two writes to one register retire two
    always_comb begin
        for (int r = 0; r < DEPTH; r++) begin
            dec[r] = {1'b0, we0 && (waddr0 == ADDR_W'(r))}
                   + {1'b0, we1 && (waddr1 == ADDR_W'(r))};
        end
    end

    always_comb begin
        uf_any = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            cnt_nxt[r] = '0;
            sum[r]     = {2'b00, cnt[r]}
                       + SW'(iss_fire && (iss_addr == ADDR_W'(r)));
            if (r != 0) begin
                if (SW'(dec[r]) > sum[r]) begin
                    uf_any = 1'b1;
                end else begin
                    cnt_nxt[r] = CNT_W'(sum[r] - SW'(dec[r]));
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem[ra];
            if (we0 && (waddr0 == ra)) rv = wdata0;
            if (we1 && (waddr1 == ra)) rv = wdata1;
            if (ra == '0)              rv = '0;
        end

        assign rd_data[i*DATA_W +: DATA_W] = rv;
        assign rd_busy[i] = (ra != '0)
                         && ({2'b00, cnt[ra]} > SW'(dec[ra]));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem[r] <= '0;
                cnt[r] <= '0;
            end
            mem[1]        <= DATA_W'(arguments);
            err_underflow <= 1'b0;
            test_result   <= '0;
        end else begin
            for (int r = 1; r < DEPTH; r++) begin
                if (we1 && (waddr1 == ADDR_W'(r))) begin
                    mem[r] <= wdata1;
                end else if (we0 && (waddr0 == ADDR_W'(r))) begin
                    mem[r] <= wdata0;
                end
                cnt[r] <= cnt_nxt[r];
            end
            if (uf_any) err_underflow <= 1'b1;
            test_result <= {mem[TAP_HI][TAP_HI_W-1:0], mem[TAP_LO]};
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a driver pushes model expectations,
// a monitor pops and compares them against the DUT outputs.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  arguments;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        we0, we1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic        iss_valid;
    logic [4:0]  iss_addr;
    logic        iss_ready;
    logic        err_underflow;
    logic [35:0] test_result;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] rd;
        logic [1:0]  busy;
        logic        rdy;
        logic        err;
        logic [35:0] tr;
    } exp_t;

    exp_t q[$];
    event mon_ev;

    logic [31:0] m_reg [32];
    int          m_cnt [32];
    bit          m_err;
    logic [35:0] m_tr;

    regfile_mp dut (
        .clk(clk), .rst(rst), .arguments(arguments),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .iss_ready(iss_ready), .err_underflow(err_underflow),
        .test_result(test_result)
    );

    always #10 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    function automatic int ndec(int a);
        return ((we0 && int'(waddr0) == a) ? 1 : 0)
             + ((we1 && int'(waddr1) == a) ? 1 : 0);
    endfunction

    function automatic bit m_ready();
        return (iss_addr == 0) || (m_cnt[iss_addr] != 3);
    endfunction

    function automatic logic [31:0] m_read(int a);
        if (a == 0) return 32'h0;
        if (we1 && int'(waddr1) == a) return wdata1;
        if (we0 && int'(waddr0) == a) return wdata0;
        return m_reg[a];
    endfunction

    // expectation for the current input set, issued at the falling edge
    task automatic apply();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            int a = int'(rd_addr[i*5 +: 5]);
            e.rd[i*32 +: 32] = m_read(a);
            e.busy[i] = (a != 0) && (m_cnt[a] - ndec(a) > 0);
        end
        e.rdy = m_ready();
        e.err = m_err;
        e.tr  = m_tr;
        q.push_back(e);
        -> mon_ev;
    endtask

    task automatic tick();
        bit rdy;
        @(posedge clk);
        rdy = m_ready();
        if (!rst) begin
            foreach (m_reg[r]) begin
                m_reg[r] = 0;
                m_cnt[r] = 0;
            end
            m_reg[1] = {26'h0, arguments};
            m_err = 0;
            m_tr  = 0;
        end else begin
            m_tr = {m_reg[13][3:0], m_reg[12]};
            for (int r = 1; r < 32; r++) begin
                int inc = (iss_valid && rdy && int'(iss_addr) == r) ? 1 : 0;
                int d   = ndec(r);
                if (d > m_cnt[r] + inc) begin
                    m_cnt[r] = 0;
                    m_err = 1;
                end else begin
                    m_cnt[r] = m_cnt[r] + inc - d;
                end
            end
            if (we0 && waddr0 != 0) m_reg[waddr0] = wdata0;
            if (we1 && waddr1 != 0) m_reg[waddr1] = wdata1;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; iss_valid = 0;
        waddr0 = 0; waddr1 = 0; wdata0 = 0; wdata1 = 0; iss_addr = 0;
    endtask

    task automatic cyc();
        apply();
        tick();
    endtask

    task automatic issue(int a);
        idle();
        iss_valid = 1;
        iss_addr = 5'(a);
        cyc();
    endtask

    initial begin
        exp_t e;
        forever begin
            @(mon_ev);
            #2;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty t=%0t actual=0 required=1", $time);
            end else begin
                e = q.pop_front();
                chk("rd_data", rd_data, e.rd);
                chk("rd_busy", 64'(rd_busy), 64'(e.busy));
                chk("iss_ready", 64'(iss_ready), 64'(e.rdy));
                chk("err_underflow", 64'(err_underflow), 64'(e.err));
                chk("test_result", 64'(test_result), 64'(e.tr));
            end
        end
    end

    initial begin
        foreach (m_reg[r]) begin
            m_reg[r] = 0;
            m_cnt[r] = 0;
        end
        m_err = 0;
        m_tr  = 0;
        idle();
        rd_addr = 0;
        rst = 0;
        arguments = 6'h2A;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1;

        rd_addr = {5'd0, 5'd1};
        apply();
        #3;
        chk("reset_reg1", rd_data, {32'h0, 32'h0000002A});
        chk("reset_busy", 64'(rd_busy), 64'h0);
        chk("reset_tap", 64'(test_result), 64'h0);
        tick();

        issue(5);
        issue(7);
        issue(7);
        issue(12);
        issue(13);

        idle();
        we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
        rd_addr = {5'd0, 5'd5};
        apply();
        #3;
        chk("bypass_w0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        tick();
        idle();
        apply();
        #3;
        chk("stored_r5", 64'(rd_data[31:0]), 64'hDEADBEEF);
        tick();

        we0 = 1; waddr0 = 7; wdata0 = 32'h11;
        we1 = 1; waddr1 = 7; wdata1 = 32'h22;
        rd_addr = {5'd0, 5'd7};
        apply();
        #3;
        chk("w1_wins_bypass", 64'(rd_data[31:0]), 64'h22);
        tick();
        idle();
        apply();
        #3;
        chk("w1_wins_stored", 64'(rd_data[31:0]), 64'h22);
        tick();

        for (int k = 0; k < 3; k++) begin
            idle();
            iss_valid = 1; iss_addr = 9;
            apply();
            #3;
            chk("iss_ready_fill", 64'(iss_ready), 64'h1);
            tick();
        end
        iss_valid = 1; iss_addr = 9;
        apply();
        #3;
        chk("iss_full", 64'(iss_ready), 64'h0);
        tick();
        idle();
        we0 = 1; waddr0 = 9; wdata0 = 32'h9;
        we1 = 1; waddr1 = 9; wdata1 = 32'h99;
        rd_addr = {5'd0, 5'd9};
        apply();
        #3;
        chk("busy_two_wb", 64'(rd_busy[0]), 64'h1);
        tick();
        idle();
        we0 = 1; waddr0 = 9; wdata0 = 32'h999;
        apply();
        #3;
        chk("busy_last_wb", 64'(rd_busy[0]), 64'h0);
        tick();

        idle();
        we0 = 1; waddr0 = 12; wdata0 = 32'h12345678;
        we1 = 1; waddr1 = 13; wdata1 = 32'hF5;
        cyc();
        idle();
        cyc();
        apply();
        #3;
        chk("tap", 64'(test_result), 64'h512345678);
        tick();

        we0 = 1; waddr0 = 0; wdata0 = 32'hFFFF;
        rd_addr = {5'd0, 5'd0};
        apply();
        #3;
        chk("r0_bypass", rd_data, 64'h0);
        chk("r0_no_err", 64'(err_underflow), 64'h0);
        tick();
        idle();
        cyc();

        we0 = 1; waddr0 = 3; wdata0 = 32'h3;
        cyc();
        idle();
        apply();
        #3;
        chk("underflow_set", 64'(err_underflow), 64'h1);
        tick();
        cyc();

        issue(4);
        issue(4);
        issue(6);
        idle();
        iss_valid = 1; iss_addr = 4;
        rst = 0;
        arguments = 6'h15;
        cyc();
        rst = 1;
        idle();
        iss_addr = 4;
        rd_addr = {5'd4, 5'd1};
        apply();
        #3;
        chk("rst_ready", 64'(iss_ready), 64'h1);
        chk("rst_err", 64'(err_underflow), 64'h0);
        chk("rst_reg1", 64'(rd_data[31:0]), 64'h15);
        chk("rst_busy", 64'(rd_busy[1]), 64'h0);
        tick();

        for (int n = 0; n < 3000; n++) begin
            rst       = ($urandom_range(0, 299) != 0);
            arguments = 6'($urandom);
            rd_addr   = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
            we0       = ($urandom_range(0, 2) == 0);
            waddr0    = 5'($urandom_range(0, 15));
            wdata0    = $urandom;
            we1       = ($urandom_range(0, 2) == 0);
            waddr1    = 5'($urandom_range(0, 15));
            wdata1    = $urandom;
            iss_valid = ($urandom_range(0, 1) == 0);
            iss_addr  = 5'($urandom_range(0, 15));
            cyc();
        end

        idle();
        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
